branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
Parametrised successor to the EX-stage branch decision logic. It resolves conditional branches from funct3 and the ALU flags, and adds a direct-mapped branch history table (BHT) of saturating counters. The BHT gives IF-stage predictions, detects mispredictions at EX for the pipeline flush, and keeps saturating branch and mispredict statistics counters. It sits between the IF predecode/PC mux and the EX-stage ALU flag outputs.

Parameters:
PC_WIDTH, 32, width of program-counter inputs
BHT_ENTRIES, 16, number of BHT entries; power of two, minimum 2
CTR_WIDTH, 2, bits per saturating prediction counter; minimum 1
STAT_WIDTH, 32, width of each statistics counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
IF_PC  input  PC_WIDTH  PC of instruction in fetch
IF_Branch  input  1  predecode: fetched instruction is a conditional branch
Predict_Taken  output  1  prediction for IF_PC
EX_Branch  input  1  instruction in EX is a conditional branch (valid this cycle)
EX_PC  input  PC_WIDTH  PC of branch in EX
EX_Predicted  input  1  prediction carried down the pipeline with this branch
funct3  input  3  branch condition code
Zflag  input  1  ALU zero flag
Sflag  input  1  ALU sign flag
Vflag  input  1  ALU overflow flag
Cflag  input  1  ALU carry flag
BranchTaken  output  1  resolved outcome
Mispredict  output  1  resolved outcome differs from EX_Predicted; flush request
Branch_Count  output  STAT_WIDTH  number of valid branches resolved
Mispredict_Count  output  STAT_WIDTH  number of mispredictions

Behaviour:
- Index: IDX = log2(BHT_ENTRIES) bits, taken from PC[IDX+1:2]. PC bits [1:0] are ignored.
- Reset (rst low, asynchronous):
  - Every BHT counter is set to weakly-not-taken, 2^(CTR_WIDTH-1)-1. For CTR_WIDTH=1 this is 0.
  - Branch_Count = 0 and Mispredict_Count = 0.
  - Combinational outputs follow their inputs; with reset state the prediction is 0.
- Prediction (combinational, zero latency):
  - Predict_Taken = IF_Branch & MSB of counter[IF index].
  - No bypass: a same-cycle EX update to the same index is not visible until the next cycle.
- Resolution (combinational in EX). cond by funct3:
  - 000 Zflag; 001 ~Zflag; 100 Sflag!=Vflag; 101 Sflag==Vflag; 110 ~Cflag; 111 Cflag.
  - 010 and 011 are illegal and give cond = 0.
  - BranchTaken = EX_Branch & cond.
  - Mispredict = EX_Branch & legal funct3 & (cond != EX_Predicted).
- Table update, at the rising clock edge when EX_Branch=1 and funct3 is legal:
  - Taken: counter[EX index] increments, saturating at all ones.
  - Not taken: counter[EX index] decrements, saturating at 0.
  - Illegal funct3 or EX_Branch=0: no table write.
- Statistics, at the rising clock edge:
  - Branch_Count += 1 when EX_Branch & legal funct3.
  - Mispredict_Count += 1 when Mispredict.
  - Both saturate at all ones and never wrap.
  - Both may increment in the same cycle.
- Aliasing: PCs sharing an index share a counter. No tag is kept.
- Reset mid-operation: any in-flight update is lost and all state returns to reset values immediately, with no clock needed.

Test Plan:
- Reset, then IF_Branch=1, IF_PC=0x40 -> Predict_Taken=0. Branch_Count=0 and Mispredict_Count=0.
- Resolve funct3=000, Zflag=1 at EX_PC=0x40 for two cycles, with EX_Predicted=0 then 0 -> BranchTaken=1 and Mispredict=1 both cycles. Counter goes 01->10->11. From the next cycle, Predict_Taken=1 for IF_PC=0x40. Counts are 2/2.
- Drive all six legal funct3 codes across flag combinations (e.g. 100 with S=1,V=0 -> taken; 110 with C=1 -> not taken) -> BranchTaken matches the table. Drive funct3=010 -> BranchTaken=0, Mispredict=0, no table write, no count change.
- Same cycle: EX update to index 3 (taken) while IF_PC maps to index 3 -> Predict_Taken shows the old counter that cycle and the new one the following cycle. Check aliasing: PC 0x0C and 0x4C with BHT_ENTRIES=16 share a counter.
- Saturation: eight taken resolves on one index -> counter holds 11. Set STAT_WIDTH=4 and run 20 mispredicts -> both counts stick at 15.
- Assert rst low mid-stream with counters non-zero and an EX branch pending -> outputs clear asynchronously and all counters read 01 afterwards. Repeat with BHT_ENTRIES=64 and CTR_WIDTH=3, where reset value is 011 and prediction needs a counter of at least 100.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch resolution for the EX stage plus a direct-mapped table of
// saturating counters that predicts conditional branches in IF and
// tracks branch/mispredict statistics.
module branch_predict_unit #(
    parameter int PC_WIDTH    = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_WIDTH   = 2,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   IF_PC,
    input  logic                  IF_Branch,
    output logic                  Predict_Taken,
    input  logic                  EX_Branch,
    input  logic [PC_WIDTH-1:0]   EX_PC,
    input  logic                  EX_Predicted,
    input  logic [2:0]            funct3,
    input  logic                  Zflag,
    input  logic                  Sflag,
    input  logic                  Vflag,
    input  logic                  Cflag,
    output logic                  BranchTaken,
    output logic                  Mispredict,
    output logic [STAT_WIDTH-1:0] Branch_Count,
    output logic [STAT_WIDTH-1:0] Mispredict_Count
);

    localparam int IDX = $clog2(BHT_ENTRIES);
    // Weakly-not-taken: MSB clear, all lower bits set (0 when one bit wide)
    localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    logic [IDX-1:0]        if_idx;
    logic [IDX-1:0]        ex_idx;
    logic                  cond;
    logic                  legal;
    logic                  update_en;
    logic [CTR_WIDTH-1:0]  ex_ctr;

    logic [CTR_WIDTH-1:0]  bht_q [BHT_ENTRIES];
    logic [CTR_WIDTH-1:0]  bht_d [BHT_ENTRIES];
    logic [STAT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [STAT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[1:0], IF_PC[PC_WIDTH-1:IDX+2],
                              EX_PC[1:0], EX_PC[PC_WIDTH-1:IDX+2]};

    assign if_idx = IF_PC[IDX+1:2];
    assign ex_idx = EX_PC[IDX+1:2];

    // Decode the branch condition from funct3 and the ALU flags
    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  cond = Zflag;
            F3_BNE:  cond = ~Zflag;
            F3_BLT:  cond = Sflag ^ Vflag;
            F3_BGE:  cond = ~(Sflag ^ Vflag);
            F3_BLTU: cond = ~Cflag;
            F3_BGEU: cond = Cflag;
            default: legal = 1'b0;
        endcase
    end

    assign update_en     = EX_Branch & legal;
    assign BranchTaken   = EX_Branch & cond;
    assign Mispredict    = update_en & (cond != EX_Predicted);
    // Reads the registered table only, so a same-cycle EX write is not bypassed
    assign Predict_Taken = IF_Branch & bht_q[if_idx][CTR_WIDTH-1];

    assign Branch_Count     = branch_count_q;
    assign Mispredict_Count = mispredict_count_q;
    assign ex_ctr           = bht_q[ex_idx];

    // Next-state of the counter table: saturating step on the EX entry
    always_comb begin
        bht_d = bht_q;
        if (update_en) begin
            if (cond) begin
                if (ex_ctr != '1) bht_d[ex_idx] = ex_ctr + CTR_WIDTH'(1);
            end else begin
                if (ex_ctr != '0) bht_d[ex_idx] = ex_ctr - CTR_WIDTH'(1);
            end
        end
    end

    // Next-state of the saturating statistics counters
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_en && branch_count_q != '1)
            branch_count_d = branch_count_q + STAT_WIDTH'(1);
        if (Mispredict && mispredict_count_q != '1)
            mispredict_count_d = mispredict_count_q + STAT_WIDTH'(1);
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_RESET;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule
